// File: rtl/timer_countdown_bcd.sv
// Packed-BCD hh:mm:ss countdown timer with one-cycle done pulse and latched alarm.
// Shares the seconds tick (ena) and BCD output format with the 12-hour up-counting clock.
module timer_countdown_bcd #(
   parameter logic [7:0] HH_MAX = 8'h99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       load,
   input  logic [7:0] hh_in,
   input  logic [7:0] mm_in,
   input  logic [7:0] ss_in,
   input  logic       start,
   input  logic       stop,
   input  logic       ack,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       running,
   output logic       done,
   output logic       alarm,
   output logic       load_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t     state_r, state_s;
   logic [7:0] hh_r, mm_r, ss_r;
   logic [7:0] hh_s, mm_s, ss_s;
   logic       running_r, done_r, alarm_r, load_err_r;
   logic       running_s, done_s, alarm_s, load_err_s;
   logic       load_valid_s, load_accept_s, tick_s, expire_s;
   logic       count_zero_s, count_one_s;

   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Two-digit BCD decrement; 00 wraps to the supplied value and the caller handles the borrow.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
      logic [7:0] r;
      if (v == 8'h00) begin
         r = wrap;
      end else if (v[3:0] == 4'd0) begin
         r = {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

   assign load_valid_s = bcd_ok(hh_in) && bcd_ok(mm_in) && bcd_ok(ss_in) &&
                         (mm_in <= 8'h59) && (ss_in <= 8'h59) && (hh_in <= HH_MAX);
   assign count_zero_s = ({hh_r, mm_r, ss_r} == 24'h000000);
   assign count_one_s  = ({hh_r, mm_r, ss_r} == 24'h000001);

   // Next-state, count and flag logic under the load > stop > start > tick priority.
   always_comb begin
      state_s       = state_r;
      hh_s          = hh_r;
      mm_s          = mm_r;
      ss_s          = ss_r;
      done_s        = 1'b0;
      load_err_s    = 1'b0;
      load_accept_s = 1'b0;
      tick_s        = 1'b0;
      expire_s      = 1'b0;

      if (load) begin
         if (state_r == ST_RUN) begin
            load_err_s = 1'b1;
            tick_s     = ena;
         end else if (load_valid_s) begin
            hh_s          = hh_in;
            mm_s          = mm_in;
            ss_s          = ss_in;
            state_s       = ST_IDLE;
            load_accept_s = 1'b1;
         end else begin
            load_err_s = 1'b1;
         end
      end else if (stop) begin
         if (state_r == ST_RUN) begin
            state_s = ST_PAUSE;
         end else begin
            state_s = state_r;
         end
      end else if (start) begin
         if (((state_r == ST_IDLE) || (state_r == ST_PAUSE)) && !count_zero_s) begin
            state_s = ST_RUN;
         end else if (state_r == ST_RUN) begin
            tick_s = ena;
         end else begin
            state_s = state_r;
         end
      end else if (state_r == ST_RUN) begin
         tick_s = ena;
      end else begin
         tick_s = 1'b0;
      end

      // Borrow ripples ss -> mm -> hh; reaching zero from 00:00:01 is the expiry event.
      if (tick_s) begin
         if (count_one_s) begin
            ss_s     = 8'h00;
            done_s   = 1'b1;
            expire_s = 1'b1;
            state_s  = ST_EXPIRED;
         end else begin
            ss_s = bcd_dec(ss_r, 8'h59);
            if (ss_r == 8'h00) begin
               mm_s = bcd_dec(mm_r, 8'h59);
               if (mm_r == 8'h00) begin
                  hh_s = bcd_dec(hh_r, 8'h99);
               end else begin
                  hh_s = hh_r;
               end
            end else begin
               mm_s = mm_r;
            end
         end
      end else begin
         expire_s = 1'b0;
      end

      if (expire_s) begin
         alarm_s = 1'b1;
      end else if (ack || load_accept_s) begin
         alarm_s = 1'b0;
      end else begin
         alarm_s = alarm_r;
      end

      running_s = (state_s == ST_RUN);
   end

   // State, count and output flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         hh_r       <= 8'h00;
         mm_r       <= 8'h00;
         ss_r       <= 8'h00;
         running_r  <= 1'b0;
         done_r     <= 1'b0;
         alarm_r    <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         hh_r       <= hh_s;
         mm_r       <= mm_s;
         ss_r       <= ss_s;
         running_r  <= running_s;
         done_r     <= done_s;
         alarm_r    <= alarm_s;
         load_err_r <= load_err_s;
      end
   end

   assign hh       = hh_r;
   assign mm       = mm_r;
   assign ss       = ss_r;
   assign running  = running_r;
   assign done     = done_r;
   assign alarm    = alarm_r;
   assign load_err = load_err_r;

endmodule

// File: tb/tb_timer_countdown_bcd.sv
// Bench for timer_countdown_bcd: directed scenarios with literal expectations, then
// randomized traffic checked against a seconds-count reference model.
module tb_timer_countdown_bcd;

   logic       clk;
   logic       reset, ena, load, start, stop, ack;
   logic [7:0] hh_in, mm_in, ss_in;
   logic [7:0] hh, mm, ss;
   logic       running, done, alarm, load_err;

   int total = 0;
   int bad   = 0;

   // Reference model: remaining time kept as plain seconds.
   int m_secs;
   int m_state;   // 0 idle, 1 run, 2 pause, 3 expired
   bit m_alarm, m_done, m_lerr;

   logic [27:0] exp_v;

   timer_countdown_bcd #(.HH_MAX(8'h99)) dut (
      .clk(clk), .reset(reset), .ena(ena), .load(load),
      .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
      .start(start), .stop(stop), .ack(ack),
      .hh(hh), .mm(mm), .ss(ss),
      .running(running), .done(done), .alarm(alarm), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [27:0] obs();
      return {hh, mm, ss, running, done, alarm, load_err};
   endfunction

   function automatic logic [27:0] model_vec();
      int h, m, s;
      h = m_secs / 3600;
      m = (m_secs / 60) % 60;
      s = m_secs % 60;
      return {to_bcd(h), to_bcd(m), to_bcd(s), (m_state == 1), m_done, m_alarm, m_lerr};
   endfunction

   task automatic model_update();
      bit tick, set, clr, valid;
      int d[6];
      m_done = 0; m_lerr = 0; tick = 0; set = 0; clr = 0;
      if (reset) begin
         m_secs = 0; m_state = 0; m_alarm = 0;
         return;
      end
      d[0] = hh_in / 16; d[1] = hh_in % 16; d[2] = mm_in / 16;
      d[3] = mm_in % 16; d[4] = ss_in / 16; d[5] = ss_in % 16;
      valid = 1;
      foreach (d[i]) if (d[i] > 9) valid = 0;
      if (d[2] * 10 + d[3] > 59 || d[4] * 10 + d[5] > 59 || d[0] * 10 + d[1] > 99) valid = 0;
      if (load) begin
         if (m_state == 1) begin
            m_lerr = 1; tick = ena;
         end else if (valid) begin
            m_secs = (d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5];
            m_state = 0; clr = 1;
         end else m_lerr = 1;
      end else if (stop) begin
         if (m_state == 1) m_state = 2;
      end else if (start) begin
         if ((m_state == 0 || m_state == 2) && m_secs != 0) m_state = 1;
         else if (m_state == 1) tick = ena;
      end else if (m_state == 1) tick = ena;
      if (tick) begin
         m_secs = m_secs - 1;
         if (m_secs == 0) begin m_done = 1; set = 1; m_state = 3; end
      end
      if (clr || ack) m_alarm = 0;
      if (set) m_alarm = 1;
   endtask

   task automatic tick_clk();
      model_update();
      @(posedge clk);
      #1;
      {reset, ena, load, start, stop, ack} = 6'b000000;
   endtask

   task automatic set_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      load = 1'b1; hh_in = h; mm_in = m; ss_in = s;
   endtask

   task automatic test_reset();
      reset = 1'b1; ena = 1'b1; start = 1'b1;
      tick_clk();
      exp_v = {24'h000000, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL reset got=%h want=%h", obs(), exp_v); end
   endtask

   task automatic test_countdown();
      set_load(8'h00, 8'h01, 8'h05); tick_clk();
      exp_v = {24'h000105, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL load_0105 got=%h want=%h", obs(), exp_v); end
      start = 1'b1; tick_clk();
      exp_v = {24'h000105, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL start_run got=%h want=%h", obs(), exp_v); end
      for (int i = 0; i < 60; i++) begin ena = 1'b1; tick_clk(); end
      exp_v = {24'h000005, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL tick60 got=%h want=%h", obs(), exp_v); end
      for (int i = 0; i < 4; i++) begin ena = 1'b1; tick_clk(); end
      ena = 1'b1; tick_clk();
      exp_v = {24'h000000, 4'b0110};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL expire got=%h want=%h", obs(), exp_v); end
      tick_clk();
      exp_v = {24'h000000, 4'b0010};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL done_pulse got=%h want=%h", obs(), exp_v); end
      for (int i = 0; i < 3; i++) begin ena = 1'b1; tick_clk(); end
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL expired_hold got=%h want=%h", obs(), exp_v); end
   endtask

   task automatic test_borrow();
      set_load(8'h10, 8'h00, 8'h00); tick_clk();
      exp_v = {24'h100000, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL load_clears_alarm got=%h want=%h", obs(), exp_v); end
      start = 1'b1; tick_clk();
      ena = 1'b1; tick_clk();
      exp_v = {24'h095959, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL hour_borrow got=%h want=%h", obs(), exp_v); end
      stop = 1'b1; tick_clk();
      set_load(8'h00, 8'h10, 8'h00); tick_clk();
      start = 1'b1; tick_clk();
      ena = 1'b1; tick_clk();
      exp_v = {24'h000959, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL min_borrow got=%h want=%h", obs(), exp_v); end
      stop = 1'b1; tick_clk();
   endtask

   task automatic test_load_err();
      set_load(8'h00, 8'h60, 8'h00); tick_clk();
      exp_v = {24'h000959, 4'b0001};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL bad_mm got=%h want=%h", obs(), exp_v); end
      tick_clk();
      exp_v = {24'h000959, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL err_pulse got=%h want=%h", obs(), exp_v); end
      set_load(8'h1A, 8'h00, 8'h00); tick_clk();
      exp_v = {24'h000959, 4'b0001};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL bad_hh got=%h want=%h", obs(), exp_v); end
      set_load(8'h00, 8'h00, 8'h5F); tick_clk();
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL bad_ss got=%h want=%h", obs(), exp_v); end
      start = 1'b1; tick_clk();
      set_load(8'h00, 8'h00, 8'h03); ena = 1'b1; tick_clk();
      exp_v = {24'h000958, 4'b1001};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL load_in_run got=%h want=%h", obs(), exp_v); end
   endtask

   task automatic test_stop_start();
      stop = 1'b1; tick_clk();
      set_load(8'h00, 8'h00, 8'h10); tick_clk();
      start = 1'b1; tick_clk();
      stop = 1'b1; ena = 1'b1; tick_clk();
      exp_v = {24'h000010, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL stop_tick got=%h want=%h", obs(), exp_v); end
      start = 1'b1; ena = 1'b1; tick_clk();
      exp_v = {24'h000010, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL start_tick got=%h want=%h", obs(), exp_v); end
      ena = 1'b1; tick_clk();
      exp_v = {24'h000009, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL resume_tick got=%h want=%h", obs(), exp_v); end
   endtask

   task automatic test_zero_ack();
      stop = 1'b1; tick_clk();
      set_load(8'h00, 8'h00, 8'h00); tick_clk();
      start = 1'b1; tick_clk();
      exp_v = {24'h000000, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL start_zero got=%h want=%h", obs(), exp_v); end
      set_load(8'h00, 8'h00, 8'h01); tick_clk();
      start = 1'b1; tick_clk();
      ena = 1'b1; tick_clk();
      set_load(8'h00, 8'h00, 8'h01); tick_clk();
      start = 1'b1; tick_clk();
      ena = 1'b1; ack = 1'b1; tick_clk();
      exp_v = {24'h000000, 4'b0110};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL ack_vs_set got=%h want=%h", obs(), exp_v); end
      ack = 1'b1; tick_clk();
      exp_v = {24'h000000, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL ack_clear got=%h want=%h", obs(), exp_v); end
      set_load(8'h00, 8'h00, 8'h02); tick_clk();
      start = 1'b1; tick_clk();
      exp_v = {24'h000002, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL reload_run got=%h want=%h", obs(), exp_v); end
   endtask

   task automatic test_reset_mid_run();
      stop = 1'b1; tick_clk();
      set_load(8'h05, 8'h23, 8'h42); tick_clk();
      start = 1'b1; tick_clk();
      ena = 1'b1; tick_clk();
      exp_v = {24'h052341, 4'b1000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL pre_reset got=%h want=%h", obs(), exp_v); end
      reset = 1'b1; ena = 1'b1; tick_clk();
      exp_v = {24'h000000, 4'b0000};
      total++; if (obs() !== exp_v) begin bad++; $display("FAIL mid_run_reset got=%h want=%h", obs(), exp_v); end
   endtask

   task automatic test_random();
      int fails = 0;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         ena   = ($urandom_range(0, 1) == 1);
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 15) == 0);
         ack   = ($urandom_range(0, 7) == 0);
         load  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 4) == 0) begin
            hh_in = 8'($urandom); mm_in = 8'($urandom); ss_in = 8'($urandom);
         end else begin
            hh_in = ($urandom_range(0, 7) == 0) ? to_bcd($urandom_range(0, 99)) : 8'h00;
            mm_in = to_bcd($urandom_range(0, 1));
            ss_in = to_bcd($urandom_range(0, 25));
         end
         tick_clk();
         exp_v = model_vec();
         total++;
         if (obs() !== exp_v) begin
            bad++;
            if (fails < 10) $display("FAIL random cycle=%0d got=%h want=%h", c, obs(), exp_v);
            fails++;
         end
      end
   endtask

   initial begin
      {reset, ena, load, start, stop, ack} = 6'b000000;
      hh_in = 8'h00; mm_in = 8'h00; ss_in = 8'h00;
      m_secs = 0; m_state = 0; m_alarm = 0; m_done = 0; m_lerr = 0;
      @(negedge clk);
      test_reset();
      test_countdown();
      test_borrow();
      test_load_err();
      test_stop_start();
      test_zero_ack();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
